// File: rtl/pi1_sram.sv
`default_nettype none
// ============================================================================
// Module      : pi1_sram
// Description : PerInt slave driving an external asynchronous SRAM with
//               programmable read/write wait states and write hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module pi1_sram #(
    parameter  int ARCHBITSZ     = 16,
    parameter  int SRAMADDRBITSZ = 16,
    parameter  int RDWAIT        = 2,
    parameter  int WRWAIT        = 2,
    parameter  int WRHOLD        = 1,
    localparam int ADDRBITSZ     = ARCHBITSZ - $clog2(ARCHBITSZ/8),
    localparam int SELBITSZ      = ARCHBITSZ/8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               pi1_op_i,
    input  logic [ADDRBITSZ-1:0]     pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]     pi1_data_i,
    output logic [ARCHBITSZ-1:0]     pi1_data_o,
    input  logic [SELBITSZ-1:0]      pi1_sel_i,
    output logic                     pi1_rdy_o,
    output logic [SRAMADDRBITSZ-1:0] sram_addr_o,
    output logic [ARCHBITSZ-1:0]     sram_dq_o,
    output logic                     sram_dq_oe_o,
    input  logic [ARCHBITSZ-1:0]     sram_dq_i,
    output logic                     sram_ce_n_o,
    output logic                     sram_oe_n_o,
    output logic                     sram_we_n_o,
    output logic [SELBITSZ-1:0]      sram_be_n_o
);

    localparam int c_max_wait = (RDWAIT > WRWAIT) ? ((RDWAIT > WRHOLD) ? RDWAIT : WRHOLD)
                                                  : ((WRWAIT > WRHOLD) ? WRWAIT : WRHOLD);
    localparam int CNTBITSZ   = ($clog2(c_max_wait + 1) < 1) ? 1 : $clog2(c_max_wait + 1);

    localparam logic [CNTBITSZ-1:0] c_rd_load    = CNTBITSZ'(RDWAIT - 1);
    localparam logic [CNTBITSZ-1:0] c_wr_load    = CNTBITSZ'(WRWAIT - 1);
    localparam logic [CNTBITSZ-1:0] c_whold_load = CNTBITSZ'(WRHOLD - 1);
    localparam logic [CNTBITSZ-1:0] c_cnt_one    = CNTBITSZ'(1);

    localparam logic [1:0] c_op_noop = 2'b00;
    localparam logic [1:0] c_op_rw   = 2'b11;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_rd    = 3'd1;
    localparam logic [2:0] c_st_wr    = 3'd2;
    localparam logic [2:0] c_st_whold = 3'd3;
    localparam logic [2:0] c_st_turn  = 3'd4;

    logic [2:0]               r_state;
    logic [CNTBITSZ-1:0]      r_cnt;
    logic                     r_rw;
    logic [SELBITSZ-1:0]      r_sel;
    logic                     r_rdy;
    logic [ARCHBITSZ-1:0]     r_rdata;
    logic [SRAMADDRBITSZ-1:0] r_addr;
    logic [ARCHBITSZ-1:0]     r_dq;
    logic                     r_dq_oe;
    logic                     r_ce_n;
    logic                     r_oe_n;
    logic                     r_we_n;
    logic [SELBITSZ-1:0]      r_be_n;
    logic [SRAMADDRBITSZ-1:0] w_addr;

    // Upper PerInt address bits are dropped so the SRAM aliases across the space.
    generate
        if (SRAMADDRBITSZ <= ADDRBITSZ) begin : g_addr_trunc
            assign w_addr = pi1_addr_i[SRAMADDRBITSZ-1:0];
        end else begin : g_addr_ext
            assign w_addr = {{(SRAMADDRBITSZ-ADDRBITSZ){1'b0}}, pi1_addr_i};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_sel   <= '0;
            r_rdy   <= 1'b1;
            r_rdata <= '0;
            r_addr  <= '0;
            r_dq    <= '0;
            r_dq_oe <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_be_n  <= '1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (pi1_op_i != c_op_noop) begin
                        r_addr <= w_addr;
                        r_dq   <= pi1_data_i;
                        r_sel  <= pi1_sel_i;
                        r_rw   <= (pi1_op_i == c_op_rw);
                        r_rdy  <= 1'b0;
                        if (pi1_op_i[1]) begin
                            r_state <= c_st_rd;
                            r_ce_n  <= 1'b0;
                            r_oe_n  <= 1'b0;
                            r_be_n  <= '0;
                            r_dq_oe <= 1'b0;
                            r_cnt   <= c_rd_load;
                        end else if (pi1_sel_i == '0) begin
                            // Empty write: one non-idle cycle with every strobe released.
                            r_state <= c_st_whold;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_st_wr;
                            r_ce_n  <= 1'b0;
                            r_we_n  <= 1'b0;
                            r_be_n  <= ~pi1_sel_i;
                            r_dq_oe <= 1'b1;
                            r_cnt   <= c_wr_load;
                        end
                    end
                end
                c_st_rd: begin
                    if (r_cnt == '0) begin
                        r_rdata <= sram_dq_i;
                        r_oe_n  <= 1'b1;
                        if (r_rw && (r_sel != '0)) begin
                            r_state <= c_st_turn;
                            r_dq_oe <= 1'b1;
                        end else begin
                            r_state <= c_st_idle;
                            r_rdy   <= 1'b1;
                            r_ce_n  <= 1'b1;
                            r_be_n  <= '1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_turn: begin
                    r_state <= c_st_wr;
                    r_we_n  <= 1'b0;
                    r_be_n  <= ~r_sel;
                    r_cnt   <= c_wr_load;
                end
                c_st_wr: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_whold;
                        r_we_n  <= 1'b1;
                        r_cnt   <= c_whold_load;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_whold: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_idle;
                        r_rdy   <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_be_n  <= '1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_rdy   <= 1'b1;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_be_n  <= '1;
                end
            endcase
        end
    end

    assign pi1_data_o   = r_rdata;
    assign pi1_rdy_o    = r_rdy;
    assign sram_addr_o  = r_addr;
    assign sram_dq_o    = r_dq;
    assign sram_dq_oe_o = r_dq_oe;
    assign sram_ce_n_o  = r_ce_n;
    assign sram_oe_n_o  = r_oe_n;
    assign sram_we_n_o  = r_we_n;
    assign sram_be_n_o  = r_be_n;

endmodule
`default_nettype wire
